// File: rtl/prng_stream_checker_if.sv
// Byte stream from the LFSR + S-box generator: one-cycle valid strobe with its data byte.
interface prng_stream_checker_if;
    logic       valid_in;
    logic [7:0] rand_in;

    modport master (output valid_in, output rand_in);
    modport slave  (input valid_in, input rand_in);
endinterface

// File: rtl/prng_stream_checker.sv
// Lock-step checker for the LFSR + AES S-box PRNG stream: predicts each byte, flags errors,
// and resynchronises by searching the S-box preimage of a wrong byte.
module prng_stream_checker #(
    parameter int unsigned ERR_W        = 8,
    parameter logic [7:0]  SEARCH_START = 8'h00
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [7:0]             i_seed,
    input  logic                   i_sel,
    prng_stream_checker_if.slave   s_in,
    output logic                   o_locked,
    output logic                   o_match,
    output logic                   o_mismatch,
    output logic [7:0]             o_recovered,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic [ERR_W-1:0]       o_err_cnt
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits (255 - x) bytes above the LSB.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    typedef enum logic [1:0] {StPredictInit, StPredict, StWait, StSearch} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [7:0]       r_prev;
    logic [7:0]       r_lfsr;
    logic [7:0]       r_sipo;
    logic [3:0]       r_cnt;
    logic             r_sel;
    logic [7:0]       r_expected;
    logic [7:0]       r_capture;
    logic [7:0]       r_cand;
    logic             r_locked;
    logic             r_match;
    logic             r_mismatch;
    logic [7:0]       r_recovered;
    logic             r_overrun;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_fb;
    logic [7:0]       w_lfsr_step;
    logic             w_hit_wait;
    logic             w_hit_search;
    logic             w_busy;

    assign w_fb = r_sel ? r_lfsr[7] : (r_lfsr[7] ^ r_lfsr[4] ^ r_lfsr[2]);
    assign w_lfsr_step = r_sel
        ? {r_lfsr[6], r_lfsr[5] ^ w_fb, r_lfsr[4] ^ w_fb, r_lfsr[3] ^ w_fb, r_lfsr[2:0], w_fb}
        : {r_lfsr[6:0], w_fb};
    assign w_hit_wait   = (sbox(r_expected) == s_in.rand_in);
    assign w_hit_search = (sbox(r_cand) == r_capture);
    assign w_busy       = (r_state == StPredict) || (r_state == StSearch);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StPredictInit;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StPredictInit: w_state_nxt = StPredict;
            StPredict:     if (r_cnt == 4'd8) w_state_nxt = StWait;
            StWait:        if (s_in.valid_in) w_state_nxt = w_hit_wait ? StPredictInit : StSearch;
            StSearch:      if (w_hit_search) w_state_nxt = StPredictInit;
            default:       w_state_nxt = StPredictInit;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_prev      <= 8'h00;
            r_lfsr      <= 8'h00;
            r_sipo      <= 8'h00;
            r_cnt       <= 4'd0;
            r_sel       <= 1'b0;
            r_expected  <= 8'h00;
            r_capture   <= 8'h00;
            r_cand      <= 8'h00;
            r_locked    <= 1'b0;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_recovered <= 8'h00;
            r_overrun   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            // Bytes arriving while a prediction or search is in flight are dropped.
            if (s_in.valid_in && w_busy) r_overrun <= 1'b1;
            unique case (r_state)
                StPredictInit: begin
                    r_lfsr <= r_prev ^ i_seed;
                    r_sel  <= i_sel;
                    r_cnt  <= 4'd0;
                end
                StPredict: begin
                    if (r_cnt == 4'd8) begin
                        r_expected <= r_sipo;
                    end else begin
                        r_lfsr <= w_lfsr_step;
                        r_sipo <= {r_sipo[6:0], w_fb};
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end
                StWait: begin
                    if (s_in.valid_in) begin
                        if (w_hit_wait) begin
                            r_match     <= 1'b1;
                            r_locked    <= 1'b1;
                            r_prev      <= r_expected;
                            r_recovered <= r_expected;
                        end else begin
                            r_mismatch <= 1'b1;
                            r_locked   <= 1'b0;
                            r_capture  <= s_in.rand_in;
                            r_cand     <= SEARCH_START;
                            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                end
                StSearch: begin
                    if (w_hit_search) begin
                        r_prev      <= r_cand;
                        r_recovered <= r_cand;
                    end else begin
                        r_cand <= r_cand + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy      = w_busy;
        o_locked    = r_locked;
        o_match     = r_match;
        o_mismatch  = r_mismatch;
        o_recovered = r_recovered;
        o_overrun   = r_overrun;
        o_err_cnt   = r_err_cnt;
    end

endmodule

// File: doc/prng_stream_checker.md
Name: prng_stream_checker

Overview:
- Receive-side companion to the team's 8-bit LFSR + AES S-box PRNG. It consumes the generator's valid/rand_num byte stream.
- Holds its own model of the generator: the Fibonacci or Galois LFSR reseeded each round with (previous pre-S-box byte XOR seed).
- Predicts each next output, compares it with the received byte, and flags mismatches.
- On mismatch it resynchronises by inverting the S-box with a sequential search, then recovers the pre-S-box byte.
- Sits beside the prng_chip on the same seed/sel inputs; used for on-chip self-test and stream validation.

Parameters:
- ERR_W, 8, width of saturating mismatch counter
- SEARCH_START, 8'h00, first candidate value for S-box inversion search

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- seed  input  8  seed byte, same value driven to the generator
- sel  input  1  0 = Fibonacci model, 1 = Galois model
- valid_in  input  1  one-cycle strobe from generator
- rand_in  input  8  generator output byte, sampled when valid_in=1
- locked  output  1  high while the last comparison matched
- match  output  1  one-cycle pulse on a correct byte
- mismatch  output  1  one-cycle pulse on a wrong byte
- recovered  output  8  last confirmed or recovered pre-S-box byte
- busy  output  1  high in PREDICT or SEARCH
- overrun  output  1  sticky; valid_in arrived while busy
- err_cnt  output  ERR_W  saturating mismatch count

Behaviour:
- Reset (async, active-high): state=PREDICT_INIT, prev=0, lfsr=0, sipo=0, cnt=0. Outputs locked=0, match=0, mismatch=0, recovered=0, busy=0, overrun=0, err_cnt=0.
- The S-box function is the standard AES forward S-box, implemented combinationally inside this block.
- Fibonacci model step:
  - fb = s[7]^s[4]^s[2]
  - s <= {s[6:0], fb}
  - serial bit = fb
- Galois model step:
  - fb = s[7]
  - s[7]<=s[6], s[6]<=s[5]^fb, s[5]<=s[4]^fb, s[4]<=s[3]^fb, s[3:0]<={s[2:0],fb}
  - serial bit = fb
- Model shift register: sipo <= {sipo[6:0], serial}.
- States:
  - PREDICT_INIT: lfsr <= prev^seed, sel latched, cnt <= 0. Next state PREDICT.
  - PREDICT: one model step per cycle and cnt++. After 8 steps, expected <= sipo (the 8 serial bits, first bit in MSB). Next state WAIT. busy=1.
  - WAIT: busy=0. On valid_in:
    - If Sbox(expected)==rand_in: match=1 for one cycle, locked=1, prev<=expected, recovered<=expected. Next state PREDICT_INIT.
    - Otherwise: mismatch=1 for one cycle, locked=0, err_cnt++ (saturating at all-ones), capture<=rand_in, cand<=SEARCH_START. Next state SEARCH.
  - SEARCH: busy=1. Each cycle, test Sbox(cand)==capture.
    - Hit: prev<=cand, recovered<=cand. Next state PREDICT_INIT.
    - Miss: cand<=cand+1 (8-bit wrap).
    - The S-box is bijective, so a hit always occurs within 256 cycles.
- Prediction latency: 10 cycles from entering PREDICT_INIT to WAIT. The generator period is at least 12 cycles, so the lock-step stream never overruns.
- valid_in while busy:
  - The byte is dropped and overrun is set (sticky until reset).
  - No match/mismatch pulse; err_cnt unchanged.
- Simultaneous valid_in on the cycle WAIT is entered: not sampled. Sampling is from the first WAIT cycle onward.
- seed/sel changes take effect only at the next PREDICT_INIT.
- Reset asserted mid-PREDICT or mid-SEARCH: immediate return to reset values; any partial search is discarded.

Test Plan:
- Reset, seed=8'h00, sel=0, wait for WAIT, pulse valid_in with rand_in=8'h63 -> match pulse, locked=1, recovered=8'h00, err_cnt=0.
- Reset, seed=8'h01, sel=1, valid_in with rand_in=8'h7C -> match, recovered=8'h01.
- Reset, seed=8'h01, sel=0, valid_in with rand_in=8'hD8 -> match, recovered=8'h2D.
- Reset, seed=8'h00, sel=0, valid_in with rand_in=8'h7C -> mismatch pulse, err_cnt=1, locked=0. SEARCH hits on cand=8'h01 in the 2nd SEARCH cycle -> recovered=8'h01, busy falls after PREDICT completes.
- Pulse valid_in during PREDICT -> overrun=1 and stays 1; no match/mismatch pulse; err_cnt unchanged.
- Connect to the live generator for 100 rounds with random seed and sel fixed -> zero mismatches, locked=1 throughout. Assert reset mid-SEARCH -> all outputs return to reset values the same cycle.
